as_gpio_ctrl: RTL

Memory-mapped GPIO peripheral between the core's data-memory bus and the chip GPIO pins.
- Holds output-data and direction registers and drives the tri-state pins.
- Synchronizes pin inputs.
- Emits a one-cycle cs_o strobe each time software commits a new output value, so external observers (bench, logic analyzer) sample stable pin data.

---
 rtl/as_pack.sv | 21 ++
 rtl/as_gpio_ctrl_if.sv | 27 ++
 rtl/as_sync2.sv | 23 ++
 rtl/as_gpio_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/as_pack.sv
// rtl/as_pack.sv - shared GPIO sizing, register offsets and pin vector type
package as_pack;

    localparam int unsigned nr_gpios        = 8;
    localparam int unsigned gpio_addr_width = 6;

    // Byte offsets of the GPIO register window; every register sits on an 8-byte slot.
    localparam int unsigned GPIO_DOUT_OFS = 'h00;
    localparam int unsigned GPIO_DIR_OFS  = 'h08;
    localparam int unsigned GPIO_DIN_OFS  = 'h10;
    localparam int unsigned GPIO_PEND_OFS = 'h18;
    localparam int unsigned GPIO_MASK_OFS = 'h20;

    typedef logic [nr_gpios-1:0] gpio_vec_t;

    // Slot index of a byte offset (drops the ignored low three address bits).
    function automatic int unsigned gpio_slot(input int unsigned ofs);
        return ofs >> 3;
    endfunction

endpackage

// File: rtl/as_gpio_ctrl_if.sv
// rtl/as_gpio_ctrl_if.sv - data-memory bus request/ack bundle for the GPIO peripheral
//
// Signals: req_i/we_i/addr_i/wdata_i from the bus master, rdata_o/ack_o back from the
// peripheral. master modport = core side, slave modport = peripheral side.
interface as_gpio_ctrl_if
    import as_pack::*;
#(
    parameter int ADDR_W = gpio_addr_width,
    parameter int DATA_W = 64
);
    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [DATA_W-1:0] rdata_o;
    logic              ack_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rdata_o, ack_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rdata_o, ack_o
    );
endinterface

// File: rtl/as_sync2.sv
// rtl/as_sync2.sv - parameterized two-flop synchronizer, sync active-high reset
//
// Ports: clk_i, rst_i (synchronous, active-high), d (async input), q (synchronized).
module as_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/as_gpio_ctrl.sv
// rtl/as_gpio_ctrl.sv - memory-mapped GPIO peripheral with tri-state pins and commit strobe
//
// Ports: clk_i, rst_i (synchronous, active-high), bus (as_gpio_ctrl_if.slave: req/we/addr/
// wdata in, rdata/ack out), gpio_io (tri-state pins), cs_o (DOUT commit strobe),
// irq_o (pin rising-edge interrupt).
// Optional feature macro: AS_GPIO_IRQ_EN adds IRQ_PEND (0x18, w1c) and IRQ_MASK (0x20);
// without it those offsets are unmapped and irq_o is tied low.
module as_gpio_ctrl
    import as_pack::*;
#(
    parameter int                  NR_GPIOS = nr_gpios,
    parameter int                  ADDR_W   = gpio_addr_width,
    parameter int                  DATA_W   = 64,
    parameter logic [NR_GPIOS-1:0] DIR_RST  = '1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    as_gpio_ctrl_if.slave       bus,
    inout  tri   [NR_GPIOS-1:0] gpio_io,
    output logic                cs_o,
    output logic                irq_o
);
    localparam int SW = ADDR_W - 3;

    logic [NR_GPIOS-1:0] dout;
    logic [NR_GPIOS-1:0] dir;
    logic [NR_GPIOS-1:0] din;
    logic [NR_GPIOS-1:0] wval;
    logic [SW-1:0]       slot;
    logic                sel_dout, sel_dir, sel_din, sel_pend, sel_mask;
    logic                wr;
    logic [DATA_W-1:0]   rd_val;
    logic [DATA_W-1:0]   rdata_q;
    logic                ack_q;
    logic                unused_bits;

    assign slot = bus.addr_i[ADDR_W-1:3];
    assign wval = bus.wdata_i[NR_GPIOS-1:0];
    assign wr   = bus.req_i && bus.we_i;

    assign unused_bits = ^{bus.addr_i[2:0], bus.wdata_i[DATA_W-1:NR_GPIOS]};

    assign sel_dout = (slot == SW'(gpio_slot(GPIO_DOUT_OFS)));
    assign sel_dir  = (slot == SW'(gpio_slot(GPIO_DIR_OFS)));
    assign sel_din  = (slot == SW'(gpio_slot(GPIO_DIN_OFS)));
    assign sel_pend = (slot == SW'(gpio_slot(GPIO_PEND_OFS)));
    assign sel_mask = (slot == SW'(gpio_slot(GPIO_MASK_OFS)));

    // Output pins are driven from the registers directly, so a write lands on the pins
    // in the same cycle the ack and cs_o strobe appear.
    for (genvar i = 0; i < NR_GPIOS; i++) begin : g_pin
        assign gpio_io[i] = dir[i] ? dout[i] : 1'bz;
    end

    // Driven pins are synchronized too, so they read back their own output value.
    as_sync2 #(.WIDTH(NR_GPIOS)) u_din_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     (gpio_io),
        .q     (din)
    );

`ifdef AS_GPIO_IRQ_EN
    logic [NR_GPIOS-1:0] din_d;
    logic [NR_GPIOS-1:0] pend;
    logic [NR_GPIOS-1:0] mask;
    logic [NR_GPIOS-1:0] rise;
    logic [NR_GPIOS-1:0] clr;
    logic                irq_q;

    assign rise = din & ~din_d;
    assign clr  = (wr && sel_pend) ? wval : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            din_d <= '0;
            pend  <= '0;
            mask  <= '0;
            irq_q <= 1'b0;
        end else begin
            din_d <= din;
            // A fresh edge in the clearing cycle must not be lost, so set is applied last.
            pend  <= (pend & ~clr) | rise;
            if (wr && sel_mask) begin
                mask <= wval;
            end
            irq_q <= |(pend & mask);
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        if (sel_dout) begin
            rd_val = DATA_W'(dout);
        end else if (sel_dir) begin
            rd_val = DATA_W'(dir);
        end else if (sel_din) begin
            rd_val = DATA_W'(din);
        end
`ifdef AS_GPIO_IRQ_EN
        else if (sel_pend) begin
            rd_val = DATA_W'(pend);
        end else if (sel_mask) begin
            rd_val = DATA_W'(mask);
        end
`else
        else if (sel_pend || sel_mask) begin
            rd_val = '0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout    <= '0;
            dir     <= DIR_RST;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            cs_o    <= 1'b0;
        end else begin
            ack_q   <= bus.req_i;
            // rdata is only non-zero in the ack cycle of a read.
            rdata_q <= (bus.req_i && !bus.we_i) ? rd_val : '0;
            // Strobe on every DOUT commit, even when the value is unchanged.
            cs_o    <= wr && sel_dout;
            if (wr && sel_dout) begin
                dout <= wval;
            end
            if (wr && sel_dir) begin
                dir <= wval;
            end
        end
    end

    assign bus.ack_o   = ack_q;
    assign bus.rdata_o = rdata_q;
endmodule
